// File: rtl/mbi6120_pkg.sv
// Shared definitions for the MBI6120 single-wire input decoder.
//   - default pulse-width thresholds (in clk cycles)
//   - symbol-type, FSM-state and error-code encodings
//   - classify_high(): maps a measured high time onto a symbol type
package mbi6120_pkg;

    localparam int DEF_ZERO_MAX_COUNT = 24;
    localparam int DEF_ONE_MAX_COUNT  = 70;
    localparam int DEF_GAP_MAX_COUNT  = 120;
    localparam int DEF_IDLE_COUNT     = 18000;   // 750 us at 24 MHz

    localparam int HIGH_CNT_W = 8;
    localparam int LOW_CNT_W  = 15;
    localparam int WORD_W     = 36;

    localparam logic [11:0] HDR_PREAMBLE = 12'hFFF;

    typedef enum logic [1:0] {
        SYM_ZERO = 2'd0,
        SYM_ONE  = 2'd1,
        SYM_GAP  = 2'd2,
        SYM_BAD  = 2'd3
    } sym_t;

    typedef enum logic [2:0] {
        ST_SYNC      = 3'd0,
        ST_HDR_BITS  = 3'd1,
        ST_HDR_GAP   = 3'd2,
        ST_DATA_BITS = 3'd3,
        ST_DATA_GAP  = 3'd4,
        ST_ERROR     = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE         = 2'b00;
    localparam logic [1:0] ERR_BAD_SYMBOL   = 2'b01;
    localparam logic [1:0] ERR_BAD_PREAMBLE = 2'b10;
    localparam logic [1:0] ERR_GAP_SEQ      = 2'b11;

    function automatic sym_t classify_high(input logic [HIGH_CNT_W-1:0] high_cnt,
                                           input int zero_max,
                                           input int one_max,
                                           input int gap_max);
        int h;
        h = int'(high_cnt);
        if (h <= zero_max)     return SYM_ZERO;
        else if (h <= one_max) return SYM_ONE;
        else if (h <= gap_max) return SYM_GAP;
        else                   return SYM_BAD;
    endfunction

endpackage

// File: rtl/mbi6120_symbol_rx.sv
// Symbol receiver: synchronizes data_in, measures each high pulse and each
// low period, and emits one symbol per high pulse plus a packet-sync strobe.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   data_in       raw serial line (asynchronous to clk)
//   symbol_valid  one-clock strobe, 1 clk after the synchronized falling edge
//   symbol_type   ZERO / ONE / GAP / BAD (valid with symbol_valid)
//   sync          one-clock strobe when the low time reaches IDLE_COUNT
module mbi6120_symbol_rx
    import mbi6120_pkg::*;
#(
    parameter int ZERO_MAX_COUNT = DEF_ZERO_MAX_COUNT,
    parameter int ONE_MAX_COUNT  = DEF_ONE_MAX_COUNT,
    parameter int GAP_MAX_COUNT  = DEF_GAP_MAX_COUNT,
    parameter int IDLE_COUNT     = DEF_IDLE_COUNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    output logic       symbol_valid,
    output logic [1:0] symbol_type,
    output logic       sync
);

    localparam logic [LOW_CNT_W-1:0]  IDLE_M1  = LOW_CNT_W'(IDLE_COUNT - 1);
    localparam logic [HIGH_CNT_W-1:0] HIGH_SAT = '1;
    localparam logic [LOW_CNT_W-1:0]  LOW_SAT  = '1;

    logic                  sync1_reg;
    logic                  sync2_reg;
    logic                  prev_reg;
    logic [HIGH_CNT_W-1:0] high_cnt_reg;
    logic [LOW_CNT_W-1:0]  low_cnt_reg;
    logic                  symbol_valid_reg;
    logic [1:0]            symbol_type_reg;
    logic                  sync_reg;

    logic rise;
    logic fall;

    assign rise = sync2_reg & ~prev_reg;
    assign fall = ~sync2_reg & prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg        <= 1'b0;
            sync2_reg        <= 1'b0;
            prev_reg         <= 1'b0;
            high_cnt_reg     <= '0;
            low_cnt_reg      <= '0;
            symbol_valid_reg <= 1'b0;
            symbol_type_reg  <= SYM_ZERO;
            sync_reg         <= 1'b0;
        end else begin
            sync1_reg <= data_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;

            // high_cnt holds the full pulse width in the falling-edge cycle
            if (sync2_reg) begin
                if (rise)
                    high_cnt_reg <= HIGH_CNT_W'(1);
                else if (high_cnt_reg != HIGH_SAT)
                    high_cnt_reg <= high_cnt_reg + 1'b1;
                low_cnt_reg <= '0;
            end else if (low_cnt_reg != LOW_SAT) begin
                low_cnt_reg <= low_cnt_reg + 1'b1;
            end

            symbol_valid_reg <= fall;
            symbol_type_reg  <= classify_high(high_cnt_reg, ZERO_MAX_COUNT,
                                              ONE_MAX_COUNT, GAP_MAX_COUNT);
            // Fires once per low period: the counter passes IDLE_M1 only once
            // before saturating.
            sync_reg <= ~sync2_reg && (low_cnt_reg == IDLE_M1);
        end
    end

    assign symbol_valid = symbol_valid_reg;
    assign symbol_type  = symbol_type_reg;
    assign sync         = sync_reg;

endmodule

// File: rtl/mbi6120_in.sv
// MBI6120 input decoder: turns the single-wire stream into a header strobe
// (gclk_sel, command, ic_count) and one strobe per 36-bit pixel word, and
// reports protocol errors.
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   data_in                     raw serial line
//   header_valid                strobe; gclk_sel/command/ic_count updated
//   pixel_valid                 strobe; pixel_a/b/c and pixel_index updated
//   error_strobe, error_code    strobe + code (01 symbol, 10 preamble, 11 gap)
module mbi6120_in
    import mbi6120_pkg::*;
#(
    parameter int ZERO_MAX_COUNT = DEF_ZERO_MAX_COUNT,
    parameter int ONE_MAX_COUNT  = DEF_ONE_MAX_COUNT,
    parameter int GAP_MAX_COUNT  = DEF_GAP_MAX_COUNT,
    parameter int IDLE_COUNT     = DEF_IDLE_COUNT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_in,
    output logic        header_valid,
    output logic [1:0]  gclk_sel,
    output logic [7:0]  command,
    output logic [9:0]  ic_count,
    output logic        pixel_valid,
    output logic [11:0] pixel_a,
    output logic [11:0] pixel_b,
    output logic [11:0] pixel_c,
    output logic [9:0]  pixel_index,
    output logic        error_strobe,
    output logic [1:0]  error_code
);

    logic       sym_valid;
    logic [1:0] sym_type;
    logic       sync_pulse;

    mbi6120_symbol_rx #(
        .ZERO_MAX_COUNT (ZERO_MAX_COUNT),
        .ONE_MAX_COUNT  (ONE_MAX_COUNT),
        .GAP_MAX_COUNT  (GAP_MAX_COUNT),
        .IDLE_COUNT     (IDLE_COUNT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .symbol_valid (sym_valid),
        .symbol_type  (sym_type),
        .sync         (sync_pulse)
    );

    state_t      state_reg, state_next;
    // Only the first 35 bits are stored; the 36th comes straight from the symbol.
    logic [34:0] shift_reg, shift_next;
    logic [5:0]  bit_cnt_reg, bit_cnt_next;
    logic        gap_cnt_reg, gap_cnt_next;
    logic [10:0] word_cnt_reg, word_cnt_next;
    logic        header_valid_reg, header_valid_next;
    logic [1:0]  gclk_sel_reg, gclk_sel_next;
    logic [7:0]  command_reg, command_next;
    logic [9:0]  ic_count_reg, ic_count_next;
    logic        pixel_valid_reg, pixel_valid_next;
    logic [11:0] pixel_reg [3];
    logic [11:0] pixel_next [3];
    logic [9:0]  pixel_index_reg, pixel_index_next;
    logic        error_strobe_reg, error_strobe_next;
    logic [1:0]  error_code_reg, error_code_next;

    logic [35:0] shifted;
    logic [11:0] word_slice [3];
    logic        is_bit;
    logic [10:0] word_total;
    logic        err_flag;
    logic [1:0]  err_val;

    assign shifted    = {shift_reg, (sym_type == SYM_ONE)};
    assign is_bit     = (sym_type == SYM_ZERO) || (sym_type == SYM_ONE);
    assign word_total = (ic_count_reg == 10'd0) ? 11'd1024 : {1'b0, ic_count_reg};

    // word_slice[0] = bits [35:24] (pixel_a) ... word_slice[2] = bits [11:0]
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slice
            assign word_slice[gi] = shifted[35 - 12*gi -: 12];
        end
    endgenerate

    always_comb begin
        state_next        = state_reg;
        shift_next        = shift_reg;
        bit_cnt_next      = bit_cnt_reg;
        gap_cnt_next      = gap_cnt_reg;
        word_cnt_next     = word_cnt_reg;
        header_valid_next = 1'b0;
        gclk_sel_next     = gclk_sel_reg;
        command_next      = command_reg;
        ic_count_next     = ic_count_reg;
        pixel_valid_next  = 1'b0;
        pixel_next        = pixel_reg;
        pixel_index_next  = pixel_index_reg;
        error_strobe_next = 1'b0;
        error_code_next   = error_code_reg;
        err_flag          = 1'b0;
        err_val           = ERR_NONE;

        case (state_reg)
            ST_SYNC, ST_ERROR: begin
                if (sync_pulse) begin
                    state_next   = ST_HDR_BITS;
                    bit_cnt_next = '0;
                    gap_cnt_next = 1'b0;
                end
            end
            default: begin
                if (sync_pulse) begin
                    // A new packet starts: drop whatever was in flight.
                    state_next   = ST_HDR_BITS;
                    bit_cnt_next = '0;
                    gap_cnt_next = 1'b0;
                end else if (sym_valid) begin
                    if (sym_type == SYM_BAD) begin
                        err_flag = 1'b1;
                        err_val  = ERR_BAD_SYMBOL;
                    end else begin
                        case (state_reg)
                            ST_HDR_BITS, ST_DATA_BITS: begin
                                if (!is_bit) begin
                                    err_flag = 1'b1;
                                    err_val  = ERR_GAP_SEQ;
                                end else begin
                                    shift_next = shifted[34:0];
                                    if (bit_cnt_reg == 6'd35) begin
                                        bit_cnt_next = '0;
                                        gap_cnt_next = 1'b0;
                                        if (state_reg == ST_HDR_BITS) begin
                                            if (shifted[35:24] != HDR_PREAMBLE) begin
                                                err_flag = 1'b1;
                                                err_val  = ERR_BAD_PREAMBLE;
                                            end else begin
                                                gclk_sel_next     = shifted[21:20];
                                                command_next      = shifted[19:12];
                                                ic_count_next     = shifted[9:0];
                                                header_valid_next = 1'b1;
                                                word_cnt_next     = '0;
                                                state_next        = ST_HDR_GAP;
                                            end
                                        end else begin
                                            pixel_next       = word_slice;
                                            pixel_index_next = word_cnt_reg[9:0];
                                            pixel_valid_next = 1'b1;
                                            word_cnt_next    = word_cnt_reg + 1'b1;
                                            state_next       = ST_DATA_GAP;
                                        end
                                    end else begin
                                        bit_cnt_next = bit_cnt_reg + 1'b1;
                                    end
                                end
                            end
                            ST_HDR_GAP, ST_DATA_GAP: begin
                                if (is_bit) begin
                                    err_flag = 1'b1;
                                    err_val  = ERR_GAP_SEQ;
                                end else if (!gap_cnt_reg) begin
                                    gap_cnt_next = 1'b1;
                                end else begin
                                    gap_cnt_next = 1'b0;
                                    bit_cnt_next = '0;
                                    if (state_reg == ST_DATA_GAP && word_cnt_reg == word_total)
                                        state_next = ST_SYNC;
                                    else
                                        state_next = ST_DATA_BITS;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        if (err_flag) begin
            error_strobe_next = 1'b1;
            error_code_next   = err_val;
            state_next        = ST_ERROR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_SYNC;
            shift_reg        <= '0;
            bit_cnt_reg      <= '0;
            gap_cnt_reg      <= 1'b0;
            word_cnt_reg     <= '0;
            header_valid_reg <= 1'b0;
            gclk_sel_reg     <= '0;
            command_reg      <= '0;
            ic_count_reg     <= '0;
            pixel_valid_reg  <= 1'b0;
            for (int i = 0; i < 3; i++) pixel_reg[i] <= '0;
            pixel_index_reg  <= '0;
            error_strobe_reg <= 1'b0;
            error_code_reg   <= ERR_NONE;
        end else begin
            state_reg        <= state_next;
            shift_reg        <= shift_next;
            bit_cnt_reg      <= bit_cnt_next;
            gap_cnt_reg      <= gap_cnt_next;
            word_cnt_reg     <= word_cnt_next;
            header_valid_reg <= header_valid_next;
            gclk_sel_reg     <= gclk_sel_next;
            command_reg      <= command_next;
            ic_count_reg     <= ic_count_next;
            pixel_valid_reg  <= pixel_valid_next;
            for (int i = 0; i < 3; i++) pixel_reg[i] <= pixel_next[i];
            pixel_index_reg  <= pixel_index_next;
            error_strobe_reg <= error_strobe_next;
            error_code_reg   <= error_code_next;
        end
    end

    assign header_valid = header_valid_reg;
    assign gclk_sel     = gclk_sel_reg;
    assign command      = command_reg;
    assign ic_count     = ic_count_reg;
    assign pixel_valid  = pixel_valid_reg;
    assign pixel_a      = pixel_reg[0];
    assign pixel_b      = pixel_reg[1];
    assign pixel_c      = pixel_reg[2];
    assign pixel_index  = pixel_index_reg;
    assign error_strobe = error_strobe_reg;
    assign error_code   = error_code_reg;

endmodule

// File: tb/tb_mbi6120_in.sv
// Scoreboard bench for mbi6120_in: stimulus pushes the expected event
// (header / pixel / error) into a queue, a monitor pops and compares on
// every strobe. IDLE_COUNT is shortened to keep run time small.
module tb_mbi6120_in;

    localparam int IDLE   = 1000;
    localparam int LOW_W  = 8;
    localparam int ZERO_W = 10;
    localparam int ONE_W  = 40;
    localparam int GAP_W  = 90;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_in = 1'b0;
    logic        header_valid;
    logic [1:0]  gclk_sel;
    logic [7:0]  command;
    logic [9:0]  ic_count;
    logic        pixel_valid;
    logic [11:0] pixel_a, pixel_b, pixel_c;
    logic [9:0]  pixel_index;
    logic        error_strobe;
    logic [1:0]  error_code;

    int total  = 0;
    int passed = 0;
    logic [79:0] exp_q[$];

    always #5 clk = ~clk;

    mbi6120_in #(.IDLE_COUNT(IDLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .header_valid (header_valid),
        .gclk_sel     (gclk_sel),
        .command      (command),
        .ic_count     (ic_count),
        .pixel_valid  (pixel_valid),
        .pixel_a      (pixel_a),
        .pixel_b      (pixel_b),
        .pixel_c      (pixel_c),
        .pixel_index  (pixel_index),
        .error_strobe (error_strobe),
        .error_code   (error_code)
    );

    function automatic logic [79:0] ev_hdr(logic [1:0] g, logic [7:0] c, logic [9:0] ic);
        return {2'd0, 58'd0, g, c, ic};
    endfunction
    function automatic logic [79:0] ev_pix(logic [11:0] a, logic [11:0] b, logic [11:0] c, logic [9:0] idx);
        return {2'd1, 32'd0, a, b, c, idx};
    endfunction
    function automatic logic [79:0] ev_err(logic [1:0] code);
        return {2'd2, 76'd0, code};
    endfunction
    function automatic logic [35:0] mk_hdr(logic [11:0] pre, logic [1:0] g, logic [7:0] c, logic [9:0] ic);
        return {pre, 2'b00, g, c, 2'b00, ic};
    endfunction
    function automatic logic [79:0] all_outs();
        return {9'd0, header_valid, pixel_valid, error_strobe, gclk_sel, command, ic_count,
                pixel_a, pixel_b, pixel_c, pixel_index, error_code};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic monitor();
        logic [79:0] act;
        int n;
        forever begin
            @(negedge clk);
            if (!rst && (header_valid || pixel_valid || error_strobe)) begin
                n = int'(header_valid) + int'(pixel_valid) + int'(error_strobe);
                check("strobe_exclusive", 80'(n), 80'd1);
                if (header_valid)     act = ev_hdr(gclk_sel, command, ic_count);
                else if (pixel_valid) act = ev_pix(pixel_a, pixel_b, pixel_c, pixel_index);
                else                  act = ev_err(error_code);
                $display("event t=%0t kind=%0d data=%h", $time, act[79:78], act[77:0]);
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_event: got %h expected none", act);
                end else begin
                    check("event", act, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic send_sym(input int high_clks);
        @(negedge clk);
        data_in = 1'b1;
        repeat (high_clks) @(negedge clk);
        data_in = 1'b0;
        repeat (LOW_W) @(negedge clk);
    endtask

    task automatic send_word(input logic [35:0] w, input int zw, input int ow);
        for (int i = 35; i >= 0; i--) send_sym(w[i] ? ow : zw);
    endtask

    task automatic gaps(input int gw);
        send_sym(gw);
        send_sym(gw);
    endtask

    task automatic idle();
        data_in = 1'b0;
        repeat (IDLE + 20) @(negedge clk);
    endtask

    logic [35:0] w0, w1, w2;

    initial begin
        fork
            monitor();
        join_none

        w0 = {12'h123, 12'h456, 12'h789};
        w1 = {12'hABC, 12'hDEF, 12'h001};
        w2 = {12'h111, 12'h222, 12'h333};

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 80'd0);
        rst = 1'b0;

        // Nominal frame: header ic_count=2, two words, then back to SYNC.
        idle();
        exp_q.push_back(ev_hdr(2'b01, 8'h00, 10'd2));
        exp_q.push_back(ev_pix(12'h123, 12'h456, 12'h789, 10'd0));
        exp_q.push_back(ev_pix(12'hABC, 12'hDEF, 12'h001, 10'd1));
        send_word(mk_hdr(12'hFFF, 2'b01, 8'h00, 10'd2), ZERO_W, ONE_W); gaps(GAP_W);
        send_word(w0, ZERO_W, ONE_W); gaps(GAP_W);
        send_word(w1, ZERO_W, ONE_W); gaps(GAP_W);
        send_word(w1, ZERO_W, ONE_W);            // in SYNC: must be ignored

        // Bad preamble, then nothing until the next idle.
        idle();
        exp_q.push_back(ev_err(2'b10));
        send_word(mk_hdr(12'hFFE, 2'b01, 8'h00, 10'd2), ZERO_W, ONE_W); gaps(GAP_W);
        send_word(w0, ZERO_W, ONE_W); gaps(GAP_W);
        idle();
        exp_q.push_back(ev_hdr(2'b10, 8'h5A, 10'd1));
        exp_q.push_back(ev_pix(12'h111, 12'h222, 12'h333, 10'd0));
        send_word(mk_hdr(12'hFFF, 2'b10, 8'h5A, 10'd1), ZERO_W, ONE_W); gaps(GAP_W);
        send_word(w2, ZERO_W, ONE_W); gaps(GAP_W);

        // Single gap after a data word, then a bit.
        idle();
        exp_q.push_back(ev_hdr(2'b00, 8'h81, 10'd2));
        exp_q.push_back(ev_pix(12'h123, 12'h456, 12'h789, 10'd0));
        exp_q.push_back(ev_err(2'b11));
        send_word(mk_hdr(12'hFFF, 2'b00, 8'h81, 10'd2), ZERO_W, ONE_W); gaps(GAP_W);
        send_word(w0, ZERO_W, ONE_W);
        send_sym(GAP_W);
        send_sym(ONE_W);

        // 200-clock pulse mid-word.
        idle();
        exp_q.push_back(ev_hdr(2'b01, 8'h00, 10'd2));
        exp_q.push_back(ev_err(2'b01));
        send_word(mk_hdr(12'hFFF, 2'b01, 8'h00, 10'd2), ZERO_W, ONE_W); gaps(GAP_W);
        for (int i = 0; i < 5; i++) send_sym(ONE_W);
        send_sym(200);

        // Asynchronous reset mid-pulse, frame without idle, then with idle.
        idle();
        exp_q.push_back(ev_hdr(2'b11, 8'h3C, 10'd1));
        send_word(mk_hdr(12'hFFF, 2'b11, 8'h3C, 10'd1), ZERO_W, ONE_W); gaps(GAP_W);
        for (int i = 0; i < 3; i++) send_sym(ZERO_W);
        @(negedge clk);
        data_in = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_midword_outputs", all_outs(), 80'd0);
        rst = 1'b0;
        data_in = 1'b0;
        send_word(mk_hdr(12'hFFF, 2'b11, 8'h3C, 10'd1), ZERO_W, ONE_W); gaps(GAP_W);
        send_word(w2, ZERO_W, ONE_W); gaps(GAP_W);
        idle();
        exp_q.push_back(ev_hdr(2'b11, 8'h3C, 10'd1));
        exp_q.push_back(ev_pix(12'h111, 12'h222, 12'h333, 10'd0));
        send_word(mk_hdr(12'hFFF, 2'b11, 8'h3C, 10'd1), ZERO_W, ONE_W); gaps(GAP_W);
        send_word(w2, ZERO_W, ONE_W); gaps(GAP_W);

        // Thresholds: 24 ZERO / 25 ONE, 70 ONE, 120 GAP; 71 GAP, 121 BAD.
        idle();
        exp_q.push_back(ev_hdr(2'b10, 8'hC3, 10'd1));
        exp_q.push_back(ev_pix(12'hF0F, 12'h0F0, 12'h5A5, 10'd0));
        send_word(mk_hdr(12'hFFF, 2'b10, 8'hC3, 10'd1), 24, 25); gaps(120);
        send_word({12'hF0F, 12'h0F0, 12'h5A5}, 24, 70); gaps(120);
        idle();
        exp_q.push_back(ev_err(2'b11));
        send_sym(71);
        idle();
        exp_q.push_back(ev_err(2'b01));
        send_sym(121);

        repeat (20) @(negedge clk);
        check("queue_drained", 80'(exp_q.size()), 80'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
